rip_ctrl_axil: RTL and testbench

AXI4-Lite slave control/status block that sits directly upstream of `rip_core_wrapper`. It drives the core's `run`, `mem_head` and `ret_head` inputs and observes `busy`, so a host processor can program and launch the RIP core over a memory-mapped bus. It also latches completion and counts busy cycles for the host to poll.

---
 rtl/rip_ctrl_axil.sv | 234 +++++++++++++++++++++++
 tb/tb_rip_ctrl_axil.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_ctrl_axil.sv
// rtl/rip_ctrl_axil.sv - AXI4-Lite control/status slave for the RIP core
// Holds AW and W independently, executes a write when both are present, one read outstanding.
module rip_ctrl_axil #(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int HEAD_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         sys_rst_n,
  output logic                         run,
  input  logic                         busy,
  output logic [HEAD_WIDTH-1:0]        mem_head,
  output logic [HEAD_WIDTH-1:0]        ret_head,
  input  logic [AXIL_ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic                         S_AWVALID,
  output logic                         S_AWREADY,
  input  logic [AXIL_DATA_WIDTH-1:0]   S_WDATA,
  input  logic [AXIL_DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                         S_WVALID,
  output logic                         S_WREADY,
  output logic [1:0]                   S_BRESP,
  output logic                         S_BVALID,
  input  logic                         S_BREADY,
  input  logic [AXIL_ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic                         S_ARVALID,
  output logic                         S_ARREADY,
  output logic [AXIL_DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]                   S_RRESP,
  output logic                         S_RVALID,
  input  logic                         S_RREADY
);
  localparam int AW = AXIL_ADDR_WIDTH;
  localparam int DW = AXIL_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int XW = (HEAD_WIDTH > DW) ? HEAD_WIDTH : DW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  ready_en_q;
  logic                  aw_held_q, aw_held_d;
  logic [AW-1:0]         awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  run_q, run_d;
  logic                  busy_q;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           cycles_q, cycles_d;
  logic [HEAD_WIDTH-1:0] mem_head_q, mem_head_d;
  logic [HEAD_WIDTH-1:0] ret_head_q, ret_head_d;

  logic          aw_hs, w_hs, ar_hs, wr_exec;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [XW-1:0] mem_x, ret_x;
  logic          unused_addr_bits;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a[AW-1:5] == '0) && (a[4:2] <= 3'd4);
  endfunction

  // Byte-lane merge on the bus-width view of a head, then zero-extend/truncate back.
  function automatic logic [HEAD_WIDTH-1:0] head_merge(input logic [HEAD_WIDTH-1:0] cur,
                                                       input logic [DW-1:0] d,
                                                       input logic [SW-1:0] s);
    logic [XW-1:0] x;
    logic [DW-1:0] m;
    x = XW'(cur);
    m = x[DW-1:0];
    for (int i = 0; i < SW; i++) begin
      if (s[i]) m[8*i +: 8] = d[8*i +: 8];
    end
    x = XW'(m);
    return x[HEAD_WIDTH-1:0];
  endfunction

  assign S_AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign S_WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
  assign S_ARREADY = ready_en_q & ~rvalid_q;

  assign aw_hs   = S_AWVALID & S_AWREADY;
  assign w_hs    = S_WVALID & S_WREADY;
  assign ar_hs   = S_ARVALID & S_ARREADY;
  assign wr_exec = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_addr = aw_held_q ? awaddr_q : S_AWADDR;
  assign wr_data = w_held_q ? wdata_q : S_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : S_WSTRB;
  assign mem_x   = XW'(mem_head_q);
  assign ret_x   = XW'(ret_head_q);
  assign unused_addr_bits = ^{wr_addr[1:0], S_ARADDR[1:0]};

  always_comb begin
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    run_d      = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    cycles_d   = cycles_q;
    mem_head_d = mem_head_q;
    ret_head_d = ret_head_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = S_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_WDATA;
      wstrb_d  = S_WSTRB;
    end
    if (bvalid_q && S_BREADY) bvalid_d = 1'b0;
    if (busy && cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;

    if (wr_exec) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      if (!addr_ok(wr_addr)) begin
        bresp_d = RESP_SLVERR;
      end else begin
        case (wr_addr[4:2])
          3'd0: if (wr_data[0] && wr_strb[0]) begin
            if (busy) begin
              err_d = 1'b1;
            end else begin
              run_d    = 1'b1;
              done_d   = 1'b0;
              cycles_d = '0;
            end
          end
          3'd1: if (wr_strb[0]) begin
            if (wr_data[1]) done_d = 1'b0;
            if (wr_data[2]) err_d = 1'b0;
          end
          3'd2: if (busy) bresp_d = RESP_SLVERR;
                else mem_head_d = head_merge(mem_head_q, wr_data, wr_strb);
          3'd3: if (busy) bresp_d = RESP_SLVERR;
                else ret_head_d = head_merge(ret_head_q, wr_data, wr_strb);
          default: ;
        endcase
      end
    end

    // Completion must not be lost to a coincident W1C, so the set is applied last.
    if (busy_q && !busy) done_d = 1'b1;
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && S_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      if (!addr_ok(S_ARADDR)) begin
        rresp_d = RESP_SLVERR;
      end else begin
        case (S_ARADDR[4:2])
          3'd1:    rdata_d = DW'({err_q, done_q, busy});
          3'd2:    rdata_d = mem_x[DW-1:0];
          3'd3:    rdata_d = ret_x[DW-1:0];
          3'd4:    rdata_d = DW'(cycles_q);
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cycles_q   <= '0;
      mem_head_q <= '0;
      ret_head_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      run_q      <= run_d;
      busy_q     <= busy;
      done_q     <= done_d;
      err_q      <= err_d;
      cycles_q   <= cycles_d;
      mem_head_q <= mem_head_d;
      ret_head_q <= ret_head_d;
    end
  end

  assign run      = run_q;
  assign mem_head = mem_head_q;
  assign ret_head = ret_head_q;
  assign S_BVALID = bvalid_q;
  assign S_BRESP  = bresp_q;
  assign S_RVALID = rvalid_q;
  assign S_RDATA  = rdata_q;
  assign S_RRESP  = rresp_q;
endmodule

// File: tb/tb_rip_ctrl_axil.sv
// tb/tb_rip_ctrl_axil.sv - scoreboard bench for rip_ctrl_axil
module tb_rip_ctrl_axil;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        run;
  logic        busy;
  logic [31:0] mem_head, ret_head;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID, S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID, S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID, S_BREADY;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID, S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID, S_RREADY;

  int checks = 0;
  int failures = 0;
  rd_exp_t    rq[$];
  logic [1:0] bq[$];

  rip_ctrl_axil dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .run(run), .busy(busy),
    .mem_head(mem_head), .ret_head(ret_head),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input logic [1:0] er,
                           output logic run_exec, output logic run_next);
    int t;
    bit aw_done, w_done, awr, wr;
    logic [1:0] e;
    bq.push_back(er);
    t = 0; aw_done = 0; w_done = 0;
    S_WDATA = d; S_WSTRB = s; S_WVALID = 1'b1;
    S_AWADDR = a; S_AWVALID = (lead == 0);
    while (!(aw_done && w_done) && t < 40) begin
      awr = S_AWREADY; wr = S_WREADY;
      @(posedge clk); #1; t++;
      if (S_AWVALID && awr) begin aw_done = 1; S_AWVALID = 1'b0; end
      if (S_WVALID && wr) begin w_done = 1; S_WVALID = 1'b0; end
      if (!aw_done && t >= lead) S_AWVALID = 1'b1;
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    run_exec = run;
    checks++;
    if (S_BVALID !== 1'b1) begin
      failures++;
      $display("FAIL bvalid_latency addr=%h got=%b exp=1", a, S_BVALID);
    end
    e = bq.pop_front();
    checks++;
    if (S_BRESP !== e) begin
      failures++;
      $display("FAIL bresp addr=%h got=%b exp=%b", a, S_BRESP, e);
    end
    S_BREADY = 1'b1;
    @(posedge clk); #1;
    S_BREADY = 1'b0;
    run_next = run;
    checks++;
    if (S_BVALID !== 1'b0) begin
      failures++;
      $display("FAIL bvalid_clear addr=%h got=%b exp=0", a, S_BVALID);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input int hold, input string nm);
    rd_exp_t e;
    logic [31:0] d0;
    int t;
    bit arr, hs;
    rq.push_back('{d: ed, r: er});
    S_ARADDR = a; S_ARVALID = 1'b1; t = 0; hs = 0;
    while (!hs && t < 20) begin
      arr = S_ARREADY;
      @(posedge clk); #1; t++;
      if (arr) hs = 1;
    end
    S_ARVALID = 1'b0;
    checks++;
    if (S_RVALID !== 1'b1) begin
      failures++;
      $display("FAIL %s rvalid_latency got=%b exp=1", nm, S_RVALID);
    end
    d0 = S_RDATA;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (S_RVALID !== 1'b1 || S_RDATA !== d0 || S_ARREADY !== 1'b0) begin
        failures++;
        $display("FAIL %s r_hold rvalid=%b rdata=%h arready=%b exp 1/%h/0", nm, S_RVALID, S_RDATA, S_ARREADY, d0);
      end
    end
    e = rq.pop_front();
    checks++;
    if (S_RDATA !== e.d || S_RRESP !== e.r) begin
      failures++;
      $display("FAIL %s rdata=%h rresp=%b exp %h/%b", nm, S_RDATA, S_RRESP, e.d, e.r);
    end
    S_RREADY = 1'b1;
    @(posedge clk); #1;
    S_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; busy = 1'b0;
    S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 0; S_BREADY = 0;
    S_ARADDR = '0; S_ARVALID = 0; S_RREADY = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({run, mem_head, ret_head, S_BVALID, S_BRESP, S_RVALID, S_RDATA, S_RRESP,
         S_AWREADY, S_WREADY, S_ARREADY} !== '0) begin
      failures++;
      $display("FAIL reset_outputs run=%b mh=%h rh=%h bv=%b rv=%b rd=%h rdy=%b%b%b exp all 0",
               run, mem_head, ret_head, S_BVALID, S_RVALID, S_RDATA, S_AWREADY, S_WREADY, S_ARREADY);
    end
    sys_rst_n = 1'b1;
    #1;
    checks++;
    if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b000) begin
      failures++;
      $display("FAIL ready_before_edge got=%b%b%b exp=000", S_AWREADY, S_WREADY, S_ARREADY);
    end
    @(posedge clk); #1;
    checks++;
    if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_edge got=%b%b%b exp=111", S_AWREADY, S_WREADY, S_ARREADY);
    end
    axi_read(32'h04, 32'h0, OKAY, 0, "status_idle");
  endtask

  task automatic test_heads();
    logic rs, rn;
    axi_write(32'h08, 32'h8000_0000, 4'hF, 3, OKAY, rs, rn);
    axi_write(32'h0C, 32'h8001_0000, 4'hF, 3, OKAY, rs, rn);
    checks++;
    if (mem_head !== 32'h8000_0000 || ret_head !== 32'h8001_0000) begin
      failures++;
      $display("FAIL head_ports mem=%h ret=%h exp 80000000/80010000", mem_head, ret_head);
    end
    axi_read(32'h08, 32'h8000_0000, OKAY, 0, "mem_head_rb");
    axi_read(32'h0C, 32'h8001_0000, OKAY, 0, "ret_head_rb");
    axi_write(32'h0E, 32'hAABB_CCDD, 4'h2, 0, OKAY, rs, rn);
    axi_read(32'h0C, 32'h8001_CC00, OKAY, 0, "ret_head_strb");
    axi_write(32'h0C, 32'h8001_0000, 4'hF, 0, OKAY, rs, rn);
  endtask

  task automatic test_back_to_back();
    int beats;
    bit arr;
    rd_exp_t e;
    beats = 0;
    S_ARADDR = 32'h08; S_ARVALID = 1'b1; S_RREADY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      arr = S_ARREADY;
      @(posedge clk); #1;
      if (arr) rq.push_back('{d: 32'h8000_0000, r: OKAY});
      if (S_RVALID && rq.size() != 0) begin
        beats++;
        e = rq.pop_front();
        checks++;
        if (S_RDATA !== e.d || S_RRESP !== e.r) begin
          failures++;
          $display("FAIL b2b_data rdata=%h rresp=%b exp %h/%b", S_RDATA, S_RRESP, e.d, e.r);
        end
      end
    end
    S_ARVALID = 1'b0;
    @(posedge clk); #1;
    S_RREADY = 1'b0;
    checks++;
    if (beats != 5 || rq.size() != 0) begin
      failures++;
      $display("FAIL b2b_rate beats=%0d pending=%0d exp 5/0", beats, rq.size());
    end
  endtask

  task automatic test_run();
    logic rs, rn;
    axi_write(32'h00, 32'h1, 4'h1, 0, OKAY, rs, rn);
    checks++;
    if (rs !== 1'b1 || rn !== 1'b0) begin
      failures++;
      $display("FAIL run_pulse exec=%b next=%b exp 1/0", rs, rn);
    end
    fork
      begin
        busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 busy = 1'b0;
      end
      axi_read(32'h04, 32'h1, OKAY, 0, "status_busy");
    join
    @(posedge clk); #1;
    axi_read(32'h04, 32'h2, OKAY, 0, "status_done");
    axi_read(32'h10, 32'd10, OKAY, 0, "cycles");
    axi_write(32'h04, 32'h2, 4'h1, 0, OKAY, rs, rn);
    axi_read(32'h04, 32'h0, OKAY, 0, "status_w1c");
  endtask

  task automatic test_busy_err();
    logic rs, rn;
    busy = 1'b1;
    axi_write(32'h00, 32'h1, 4'h1, 0, OKAY, rs, rn);
    checks++;
    if (rs !== 1'b0 || rn !== 1'b0) begin
      failures++;
      $display("FAIL run_while_busy exec=%b next=%b exp 0/0", rs, rn);
    end
    axi_read(32'h04, 32'h5, OKAY, 0, "status_err");
    axi_write(32'h08, 32'h0000_1234, 4'hF, 0, SLVERR, rs, rn);
    checks++;
    if (mem_head !== 32'h8000_0000) begin
      failures++;
      $display("FAIL head_busy_write mem=%h exp=80000000", mem_head);
    end
    axi_read(32'h08, 32'h8000_0000, OKAY, 0, "mem_head_busy");
  endtask

  task automatic test_w1c_race();
    logic rs, rn;
    busy = 1'b0;
    axi_write(32'h04, 32'h6, 4'h1, 0, OKAY, rs, rn);
    axi_read(32'h04, 32'h2, OKAY, 0, "done_set_wins");
    axi_write(32'h04, 32'h2, 4'h1, 0, OKAY, rs, rn);
    axi_read(32'h04, 32'h0, OKAY, 0, "status_clear");
  endtask

  task automatic test_unmapped();
    logic rs, rn;
    axi_read(32'h14, 32'h0, SLVERR, 0, "rd_0x14");
    axi_read(32'h100, 32'h0, SLVERR, 5, "rd_0x100");
    axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, 0, SLVERR, rs, rn);
    axi_read(32'h08, 32'h8000_0000, OKAY, 0, "mem_head_after_unmapped");
  endtask

  task automatic test_reset_abort();
    bit arr;
    S_ARADDR = 32'h08; S_ARVALID = 1'b1;
    arr = S_ARREADY;
    @(posedge clk); #1;
    S_ARVALID = 1'b0;
    S_WDATA = 32'h1; S_WSTRB = 4'h1; S_WVALID = 1'b1;
    @(posedge clk); #1;
    S_WVALID = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (!arr || S_RVALID !== 1'b0 || mem_head !== 32'h0 || ret_head !== 32'h0 || S_WREADY !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort arhs=%b rvalid=%b mem=%h ret=%h wready=%b exp 1/0/0/0/0",
               arr, S_RVALID, mem_head, ret_head, S_WREADY);
    end
    rq.delete();
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (S_WREADY !== 1'b1 || S_BVALID !== 1'b0) begin
      failures++;
      $display("FAIL w_not_held wready=%b bvalid=%b exp 1/0", S_WREADY, S_BVALID);
    end
    axi_read(32'h08, 32'h0, OKAY, 0, "mem_head_after_reset");
  endtask

  initial begin
    test_reset();
    test_heads();
    test_back_to_back();
    test_run();
    test_busy_err();
    test_w1c_race();
    test_unmapped();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
